serial_tx_arbiter: RTL and testbench
====================================

Name: serial_tx_arbiter

Overview:
- Shares one serial channel among NUM_REQ requesters using round-robin arbitration.
- Frames each granted word in the link format that the serial RX side decodes: start, parity, data LSB-first, stop, gap.
- Sits between producer blocks and the physical channel line. Exactly one frame is in flight at a time.

Parameters:
- BIT_LEN, 7, data bits per frame.
- NUM_REQ, 4, number of requesters (2..16).
- GAP_LEN, 1, idle-low cycles after stop bit (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester word available.
- req_data  input  NUM_REQ*BIT_LEN  packed words; requester i at [i*BIT_LEN +: BIT_LEN].
- req_ready  output  NUM_REQ  one-hot accept strobe.
- channel_out  output  1  serial line, registered; idles 0.
- busy  output  1  high whenever state != IDLE.
- grant_id  output  $clog2(NUM_REQ)  index of last accepted requester.
- tx_done  output  1  one-cycle pulse in first GAP cycle.

Behaviour:
- Reset (async, rstn low): state IDLE, channel_out 0, busy 0, grant_id 0, tx_done 0. req_ready forced to 0 while rstn is low. RR pointer set so index 0 has highest priority. An in-flight frame is aborted: the line drops to 0 immediately and no done pulse is produced.
- Frame format:
  - Start bit 1.
  - Parity bit = XOR of data.
  - BIT_LEN data bits, LSB first.
  - Stop bit 1.
  - GAP_LEN cycles of 0.
  - One bit per clk.
- States: IDLE -> START -> PARITY -> DATA (BIT_LEN cycles) -> STOP -> GAP (GAP_LEN cycles) -> IDLE.
- IDLE acceptance:
  - If any req_valid is high, the arbiter picks winner w and drives req_ready[w]=1 combinationally in the same cycle. req_ready is 0 in all other states.
  - At that clock edge: data latched into shift register, parity computed from the latched word, grant_id<=w, RR pointer<=w, next state START.
- Timing, acceptance in cycle T:
  - channel_out = 1 in cycle T+1.
  - Parity in T+2.
  - D0..D(BIT_LEN-1) in T+3..T+2+BIT_LEN.
  - Stop in T+3+BIT_LEN.
  - Gap from T+4+BIT_LEN.
  - Earliest next acceptance at T+4+BIT_LEN+GAP_LEN. Back-to-back period = BIT_LEN+4+GAP_LEN cycles (12 at defaults).
- Round robin: search order w_prev+1, w_prev+2, ... modulo NUM_REQ. The granted requester has lowest priority next time.
- Handshake rules:
  - A requester holds req_valid and req_data stable until it sees req_ready.
  - Deasserting req_valid before grant is legal; that requester is simply not considered.
  - A requester's data changing while not granted has no effect.
- Counters: bit counter $clog2(BIT_LEN+1) bits and gap counter $clog2(GAP_LEN+1) bits. Both are loaded on state entry and never wrap.
- No valid in IDLE: stay IDLE, channel_out 0, no pulses.

Optional Feature:
- Macro: SERIAL_TX_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index always wins; RR pointer logic removed.
- Undefined: round robin as above. Framing and timing are identical in both cases.

Decomposition:
- Shared package serial_link_pkg holds:
  - State encoding (IDLE, START, PARITY, DATA, STOP, GAP).
  - Constants: LINE_IDLE=0, START_BIT=1, STOP_BIT=1.
  - Parity function. The RX side reuses the same definitions.
- One sub-module: rr_arbiter (req vector, last-grant pointer -> one-hot grant + index; fixed-priority mode under the macro). Serializer FSM stays in the top.

Test Plan:
- Single word: requester 2 sends 7'h55, others idle. Expect:
  - req_ready[2] for 1 cycle, grant_id=2.
  - channel_out from T+1: 1,0,1,0,1,0,1,0,1,1,0.
  - tx_done at T+11.
- Odd parity: requester 0 sends 7'h01. Parity bit = 1; data bits 1,0,0,0,0,0,0; frame ends 1 then 0.
- Contention: all 4 requesters valid continuously.
  - Grants in order 0,1,2,3,0; acceptances exactly 12 cycles apart.
  - With SERIAL_TX_FIXED_PRIO_EN: grants 0,0,0.
- Withdrawal: requester 1 raises valid, then drops it while a frame for requester 0 is in flight; requester 3 is also valid. Next grant = 3, req_ready[1] never asserts.
- Reset mid-frame: rstn low during DATA. Expect:
  - channel_out=0 and busy=0 asynchronously.
  - No tx_done.
  - After release with requester 0 valid: fresh start bit one cycle after acceptance, grant_id=0.
- Idle line: no req_valid for 50 cycles. Expect channel_out=0, busy=0, req_ready=0 throughout.

Source files
------------

// File: rtl/serial_link_pkg.sv
// serial_link_pkg
// Shared definitions for the serial link: framing FSM state encoding,
// line-level constants and the parity helper. Both the TX arbiter and the
// RX decoder import this package so the two sides agree on the frame format.
//
// Frame on the line, one bit per clk:
//   START_BIT, parity (XOR of data), data LSB first, STOP_BIT,
//   then gap cycles at LINE_IDLE.
package serial_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_PARITY = 3'd2,
    ST_DATA   = 3'd3,
    ST_STOP   = 3'd4,
    ST_GAP    = 3'd5
  } link_state_t;

  localparam logic LINE_IDLE = 1'b0;
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b1;

  // Widest word the parity helper accepts; callers zero-extend, which does
  // not change the XOR.
  localparam int PARITY_MAX_W = 32;

  function automatic logic calc_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Picks one requester from a request vector.
//   Round-robin (default): search starts at i_last+1 and wraps modulo
//   NUM_REQ, so the previous winner has the lowest priority.
//   Fixed priority (`define SERIAL_TX_FIXED_PRIO_EN): lowest index wins and
//   i_last is ignored.
// Ports:
//   i_req   [NUM_REQ]  request vector
//   i_last  [IDX_W]    index of the previous winner
//   o_grant [NUM_REQ]  one-hot grant (all zero when no request)
//   o_idx   [IDX_W]    index of the winner (0 when no request)
//   o_any   1          at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_cand;

`ifdef SERIAL_TX_FIXED_PRIO_EN
  logic w_unused_last;
  assign w_unused_last = ^i_last;
  // Starting "after" the last index makes index 0 the first candidate.
  assign w_start = LAST_IDX;
`else
  assign w_start = i_last;
`endif

  // Walk the candidates in priority order; first requester found wins.
  // The wrap is explicit so NUM_REQ need not be a power of two.
  always_comb begin
    w_cand = w_start;
    o_any  = 1'b0;
    o_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = (w_cand == LAST_IDX) ? '0 : w_cand + 1'b1;
      if (!o_any && i_req[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
    o_grant = o_any ? (NUM_REQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
// Shares one serial line among NUM_REQ producers. In IDLE the arbiter picks a
// winner and strobes its req_ready in the same cycle; the word is latched at
// that edge and serialised as START, parity, data LSB first, STOP, then
// GAP_LEN idle cycles. One frame in flight at a time; back-to-back period is
// BIT_LEN+4+GAP_LEN cycles.
//
// Handshake: a producer holds req_valid/req_data until it sees req_ready.
// A word is transferred in a cycle where req_valid[i] and req_ready[i] are
// both high; req_ready is one-hot, only ever high in IDLE, and low while
// rstn is low. Dropping req_valid before grant withdraws the request.
//
// Ports:
//   clk, rstn      clock (rising edge), asynchronous active-low reset
//   req_valid      [NUM_REQ]          per-requester word available
//   req_data       [NUM_REQ*BIT_LEN]  requester i at [i*BIT_LEN +: BIT_LEN]
//   req_ready      [NUM_REQ]          one-hot accept strobe
//   channel_out    1                  registered serial line, idles 0
//   busy           1                  high whenever the FSM is not IDLE
//   grant_id       [$clog2(NUM_REQ)]  index of last accepted requester
//   tx_done        1                  pulse in the first GAP cycle
//
// Build option: SERIAL_TX_FIXED_PRIO_EN selects fixed priority (lowest index
// wins) and removes the round-robin pointer. Framing is unchanged.
// FSM state is held in r_state (link_state_t) for probing.
module serial_tx_arbiter
  import serial_link_pkg::*;
#(
  parameter int BIT_LEN = 7,
  parameter int NUM_REQ = 4,
  parameter int GAP_LEN = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*BIT_LEN-1:0] req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       channel_out,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       tx_done
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int BCNT_W = $clog2(BIT_LEN + 1);
  localparam int GCNT_W = $clog2(GAP_LEN + 1);

  link_state_t         r_state;
  logic                r_line;
  logic                r_done;
  logic                r_parity;
  logic [BIT_LEN-1:0]  r_shift;
  logic [BCNT_W-1:0]   r_bit_cnt;
  logic [GCNT_W-1:0]   r_gap_cnt;
  logic [IDX_W-1:0]    r_grant_id;
  logic [IDX_W-1:0]    w_last;

  logic [NUM_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]    w_win_idx;
  logic                w_any;
  logic [BIT_LEN-1:0]  w_win_data;
  logic                w_idle;

`ifdef SERIAL_TX_FIXED_PRIO_EN
  assign w_last = '0;
`else
  logic [IDX_W-1:0] r_rr_ptr;

  // Reset value NUM_REQ-1 makes index 0 the first candidate.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr_ptr <= IDX_W'(NUM_REQ - 1);
    end else if (w_idle && w_any) begin
      r_rr_ptr <= w_win_idx;
    end
  end

  assign w_last = r_rr_ptr;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req   (req_valid),
    .i_last  (w_last),
    .o_grant (w_grant),
    .o_idx   (w_win_idx),
    .o_any   (w_any)
  );

  assign w_idle     = (r_state == ST_IDLE);
  assign w_win_data = req_data[w_win_idx*BIT_LEN +: BIT_LEN];

  // rstn gates the strobe so no producer sees an accept during reset.
  assign req_ready   = (rstn && w_idle) ? w_grant : '0;
  assign channel_out = r_line;
  assign busy        = !w_idle;
  assign grant_id    = r_grant_id;
  assign tx_done     = r_done;

  // r_line always carries the bit for the state being entered, so the
  // line value lines up with r_state in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_line     <= LINE_IDLE;
      r_done     <= 1'b0;
      r_parity   <= 1'b0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_grant_id <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_line <= LINE_IDLE;
          if (w_any) begin
            r_state    <= ST_START;
            r_line     <= START_BIT;
            r_shift    <= w_win_data;
            r_parity   <= calc_parity(PARITY_MAX_W'(w_win_data));
            r_grant_id <= w_win_idx;
          end
        end
        ST_START: begin
          r_state <= ST_PARITY;
          r_line  <= r_parity;
        end
        ST_PARITY: begin
          r_state   <= ST_DATA;
          r_line    <= r_shift[0];
          r_shift   <= r_shift >> 1;
          // Counts data bits still to send after the one now on the line.
          r_bit_cnt <= BCNT_W'(BIT_LEN - 1);
        end
        ST_DATA: begin
          if (r_bit_cnt == '0) begin
            r_state <= ST_STOP;
            r_line  <= STOP_BIT;
          end else begin
            r_line    <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= r_bit_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          r_state   <= ST_GAP;
          r_line    <= LINE_IDLE;
          r_done    <= 1'b1;
          r_gap_cnt <= GCNT_W'(GAP_LEN - 1);
        end
        ST_GAP: begin
          r_line <= LINE_IDLE;
          if (r_gap_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_line  <= LINE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
module tb_serial_tx_arbiter;

  localparam int BIT_LEN   = 7;
  localparam int NUM_REQ   = 4;
  localparam int GAP_LEN   = 1;
  localparam int IW        = $clog2(NUM_REQ);
  localparam int EW        = IW + BIT_LEN;
  localparam int FRAME_LEN = BIT_LEN + 3 + GAP_LEN;
  localparam int PERIOD    = BIT_LEN + 4 + GAP_LEN;

  logic                       clk;
  logic                       rstn;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*BIT_LEN-1:0] req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       channel_out;
  logic                       busy;
  logic [IW-1:0]              grant_id;
  logic                       tx_done;

  serial_tx_arbiter #(
    .BIT_LEN (BIT_LEN),
    .NUM_REQ (NUM_REQ),
    .GAP_LEN (GAP_LEN)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .channel_out (channel_out),
    .busy        (busy),
    .grant_id    (grant_id),
    .tx_done     (tx_done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  int acc_q[$];
  int cyc = 0;
  int mon_pos = -1;
  logic [IW-1:0] mon_id;
  logic [BIT_LEN-1:0] mon_data;
  logic [EW-1:0] mon_e;
  logic [NUM_REQ-1:0] cons_mask = '0;
  bit refill = 0;
  int wcnt[NUM_REQ];
  logic [BIT_LEN-1:0] words[NUM_REQ][4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected line value at position pos (1 = cycle after acceptance).
  function automatic logic frame_bit(input logic [BIT_LEN-1:0] d, input int pos);
    logic p;
    p = 1'b0;
    for (int k = 0; k < BIT_LEN; k++) p = p ^ d[k];
    if (pos == 1) return 1'b1;
    if (pos == 2) return p;
    if (pos <= BIT_LEN + 2) return d[pos-3];
    if (pos == BIT_LEN + 3) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- monitor / comparator ----------------
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      mon_pos   = -1;
      cons_mask = '0;
    end else if (mon_pos >= 0) begin
      mon_pos++;
      check("line", 32'(channel_out), 32'(frame_bit(mon_data, mon_pos)));
      check("busy", 32'(busy), 32'd1);
      check("done", 32'(tx_done), 32'(mon_pos == BIT_LEN + 4));
      check("rdy_busy", 32'(req_ready), 32'd0);
      if (mon_pos == 1) check("grant_id", 32'(grant_id), 32'(mon_id));
      if (mon_pos == FRAME_LEN) mon_pos = -1;
    end else if (req_ready != '0) begin
      check("acc_line", 32'(channel_out), 32'd0);
      check("acc_busy", 32'(busy), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexp_grant", 32'(req_ready), 32'd0);
      end else begin
        mon_e    = exp_q.pop_front();
        mon_id   = mon_e[EW-1 -: IW];
        mon_data = mon_e[BIT_LEN-1:0];
        check("ready", 32'(req_ready), 32'(1) << mon_id);
        acc_q.push_back(cyc);
        mon_pos   = 0;
        cons_mask = req_ready;
      end
    end else begin
      check("idle_line", 32'(channel_out), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(tx_done), 32'd0);
    end
  end

  // Requester side: consume (or refill) a word right after its acceptance edge.
  always @(posedge clk) begin
    #1;
    if (rstn && cons_mask != '0) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cons_mask[i]) begin
          if (refill && wcnt[i] < 3) begin
            wcnt[i]++;
            req_data[i*BIT_LEN +: BIT_LEN] = words[i][wcnt[i]];
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      cons_mask = '0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int id, input logic [BIT_LEN-1:0] d);
    req_data[id*BIT_LEN +: BIT_LEN] = d;
    req_valid[id] = 1'b1;
    exp_q.push_back({IW'(id), d});
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && mon_pos < 0 && req_valid == '0) && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(n >= budget), 32'd0);
  endtask

  task automatic wait_pos(input int target, input int budget);
    int n;
    n = 0;
    while (mon_pos != target && n < budget) begin
      step();
      n++;
    end
    check("pos_timeout", 32'(n >= budget), 32'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) step();
    rstn = 1'b1;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rstn      = 1'b0;
    req_valid = '1;
    req_data  = '0;
    #3;
    check("rst_line", 32'(channel_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    repeat (2) step();
    rstn = 1'b1;
    step();

    // Idle line
    for (int i = 0; i < 50; i++) begin
      check("idle_rdy", 32'(req_ready), 32'd0);
      check("idle50_line", 32'(channel_out), 32'd0);
      check("idle50_busy", 32'(busy), 32'd0);
      step();
    end

    // Single word and odd parity
    send(2, 7'h55);
    wait_drain(40);
    send(0, 7'h01);
    wait_drain(40);

    // Withdrawal: pointer now at 0, requester 1 withdraws, 3 must win
    send(0, 7'($urandom_range(0, 127)));
    wait_pos(2, 40);
    req_data[1*BIT_LEN +: BIT_LEN] = 7'h3C;
    req_valid[1] = 1'b1;
    send(3, 7'($urandom_range(0, 127)));
    repeat (3) step();
    req_valid[1] = 1'b0;
    wait_drain(60);

    // Reset mid-frame
    send(2, 7'h7F);
    wait_pos(5, 40);
    check("pre_rst_line", 32'(channel_out), 32'd1);
    rstn = 1'b0;
    #1;
    check("arst_line", 32'(channel_out), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_gid", 32'(grant_id), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("arst_done", 32'(tx_done), 32'd0);
      check("arst_ready", 32'(req_ready), 32'd0);
    end
    rstn = 1'b1;
    step();
    send(0, 7'h2A);
    wait_drain(40);
    do_reset();

    // Contention
    for (int i = 0; i < NUM_REQ; i++) begin
      wcnt[i] = 0;
      for (int k = 0; k < 4; k++) words[i][k] = 7'($urandom_range(0, 127));
      req_data[i*BIT_LEN +: BIT_LEN] = words[i][0];
    end
    acc_q.delete();
`ifdef SERIAL_TX_FIXED_PRIO_EN
    for (int k = 0; k < 3; k++) exp_q.push_back({IW'(0), words[0][k]});
`else
    for (int i = 0; i < NUM_REQ; i++) exp_q.push_back({IW'(i), words[i][0]});
    exp_q.push_back({IW'(0), words[0][1]});
`endif
    n = exp_q.size();
    refill    = 1;
    req_valid = '1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) step();
    refill    = 0;
    req_valid = '0;
    wait_drain(60);
    check("b2b_count", 32'(acc_q.size()), 32'(n));
    for (int k = 1; k < acc_q.size(); k++)
      check("b2b_period", 32'(acc_q[k] - acc_q[k-1]), 32'(PERIOD));

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
